// File: rtl/hamming_serial_tx_if.sv
// ============================================================================
// Module   : hamming_serial_tx_if
// Brief    : Peripheral register bus for the Hamming (7,4) serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hamming_serial_tx_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

`default_nettype wire

// File: rtl/hamming_serial_tx.sv
// ============================================================================
// Module   : hamming_serial_tx
// Brief    : 4-deep codeword FIFO feeding a start/7-bit/stop serial framer.
//            Define HAMMING_SER_ENCODE_EN to Hamming-encode data_in[3:0] on push.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_serial_tx (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ui_in,
    output logic [7:0]         uo_out,
    hamming_serial_tx_if.slave bus
);

    localparam logic [3:0] c_ADDR_DATA   = 4'h0;
    localparam logic [3:0] c_ADDR_DIV    = 4'h1;
    localparam logic [3:0] c_ADDR_CTRL   = 4'h2;
    localparam logic [3:0] c_ADDR_STATUS = 4'h3;
    localparam logic [2:0] c_LAST_BIT    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_div;
    logic       r_en, r_ovf;
    logic [6:0] r_mem [0:3];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_level;
    logic [6:0] r_shift, w_shift_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic       r_txd, r_busy, w_txd_nxt;
    logic       w_wr_data, w_wr_div, w_wr_ctrl, w_flush, w_ovfclr;
    logic       w_empty, w_full, w_pop, w_push, w_push_ok;
    logic [6:0] w_push_word;
    logic       w_unused_ui;

    assign w_unused_ui = ^ui_in;

    assign w_wr_data = bus.data_write && (bus.address == c_ADDR_DATA);
    assign w_wr_div  = bus.data_write && (bus.address == c_ADDR_DIV);
    assign w_wr_ctrl = bus.data_write && (bus.address == c_ADDR_CTRL);
    assign w_flush   = w_wr_ctrl && bus.data_in[1];
    assign w_ovfclr  = w_wr_ctrl && bus.data_in[2];

    assign w_empty   = (r_level == 3'd0);
    assign w_full    = (r_level == 3'd4);
    assign w_push    = w_wr_data && !w_flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push_ok = w_push && (!w_full || w_pop);

`ifdef HAMMING_SER_ENCODE_EN
    logic [3:0] w_d;
    assign w_d = bus.data_in[3:0];
    assign w_push_word = {w_d[3], w_d[2], w_d[1], w_d[1] ^ w_d[2] ^ w_d[3],
                          w_d[0], w_d[0] ^ w_d[2] ^ w_d[3], w_d[0] ^ w_d[1] ^ w_d[3]};
`else
    assign w_push_word = bus.data_in[6:0];
`endif

    // Control/status registers and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= 8'h0F;
            r_en     <= 1'b0;
            r_ovf    <= 1'b0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_level  <= 3'd0;
        end else begin
            if (w_wr_div)  r_div <= bus.data_in;
            if (w_wr_ctrl) r_en  <= bus.data_in[0];
            if (w_ovfclr)
                r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            if (w_flush) begin
                r_wr_ptr <= 2'd0;
                r_rd_ptr <= 2'd0;
                r_level  <= 3'd0;
            end else begin
                if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
                r_level <= r_level + {2'b00, w_push_ok} - {2'b00, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= 7'd0;
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Every bit boundary reloads from the live DIV register.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt - 8'd1;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (r_en && !w_empty && !w_flush) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_cnt_nxt   = r_div;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_nxt   = r_div;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == 8'd0) begin
                    w_cnt_nxt = r_div;
                    if (r_idx == c_LAST_BIT) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[6:1]};
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == 8'd0) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_START: w_txd_nxt = 1'b0;
            ST_DATA:  w_txd_nxt = w_shift_nxt[0];
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    assign uo_out = {6'b000000, r_busy, r_txd};

    always_comb begin
        bus.data_out = 8'h00;
        case (bus.address)
            c_ADDR_DATA:   bus.data_out = {5'b00000, r_level};
            c_ADDR_DIV:    bus.data_out = r_div;
            c_ADDR_CTRL:   bus.data_out = {7'b0000000, r_en};
            c_ADDR_STATUS: bus.data_out = {1'b0, r_level, r_ovf, w_full, w_empty, r_busy};
            default:       bus.data_out = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hamming_serial_tx.sv
// ============================================================================
// Module   : tb_hamming_serial_tx
// Brief    : Self-checking bench for hamming_serial_tx (frames, FIFO, CSRs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_serial_tx;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    int         n_total = 0;
    int         n_pass  = 0;

    hamming_serial_tx_if bus ();

    hamming_serial_tx dut (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Hamming positional rule: parity at position 2^p covers every position with bit p set.
    function automatic logic [6:0] model_word(input logic [7:0] d);
`ifdef HAMMING_SER_ENCODE_EN
        logic [7:1] cw;
        cw    = '0;
        cw[3] = d[0];
        cw[5] = d[1];
        cw[6] = d[2];
        cw[7] = d[3];
        for (int p = 0; p < 3; p++)
            for (int pos = 1; pos < 8; pos++)
                if ((((pos >> p) & 1) == 1) && (pos != (1 << p)))
                    cw[1 << p] = cw[1 << p] ^ cw[pos];
        return cw[7:1];
`else
        return d[6:0];
`endif
    endfunction

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.data_in    = d;
        bus.data_write = 1'b1;
        @(posedge clk);
        #1;
        bus.data_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        bus.address = a;
        #1;
        d = bus.data_out;
    endtask

    // Waits (bounded) for the start bit, then samples every clock of the 9 bit slots.
    task automatic capture_frame(input int div, output int waited,
                                 output logic [8:0] slots, output bit stable, output bit busy_ok);
        logic first;
        waited  = 0;
        slots   = '0;
        stable  = 1'b1;
        busy_ok = 1'b1;
        while (uo_out[0] !== 1'b0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        for (int b = 0; b < 9; b++) begin
            first = uo_out[0];
            for (int k = 0; k <= div; k++) begin
                if (uo_out[0] !== first) stable = 1'b0;
                if (uo_out[1] !== 1'b1)  busy_ok = 1'b0;
                @(posedge clk);
                #1;
            end
            slots[b] = first;
        end
    endtask

    task automatic idle_watch(input int cycles, output int busy_cnt, output int low_cnt);
        busy_cnt = 0;
        low_cnt  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (uo_out[1] !== 1'b0) busy_cnt++;
            if (uo_out[0] !== 1'b1) low_cnt++;
        end
    endtask

    task automatic test_reset;
        logic [3:0] addrs [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hA};
        logic [7:0] exps  [5] = '{8'h00, 8'h0F, 8'h00, 8'h02, 8'h00};
        logic [7:0] got;
        bus.address    = 4'h0;
        bus.data_in    = 8'h00;
        bus.data_write = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (uo_out !== 8'h01) $display("FAIL reset_uo_out got=%h exp=01", uo_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus_rd(addrs[i], got);
            n_total++;
            if (got !== exps[i]) $display("FAIL reset_reg%0h got=%h exp=%h", addrs[i], got, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_single_frame;
        int         div, waited;
        logic [7:0] d, got;
        logic [8:0] slots;
        bit         stable, busy_ok;
`ifdef HAMMING_SER_ENCODE_EN
        d   = 8'h0B;
        div = 0;
`else
        d   = 8'h55;
        div = 3;
`endif
        bus_wr(4'h1, 8'(div));
        bus_wr(4'h2, 8'h01);
        bus_wr(4'h0, d);
        capture_frame(div, waited, slots, stable, busy_ok);
        n_total++;
        if (waited !== 1) $display("FAIL single_latency got=%0d exp=1", waited);
        else n_pass++;
        n_total++;
        if (slots !== {1'b1, 7'h55, 1'b0}) $display("FAIL single_bits got=%b exp=%b", slots, {1'b1, 7'h55, 1'b0});
        else n_pass++;
        n_total++;
        if (!stable || !busy_ok) $display("FAIL single_timing stable=%0b busy=%0b exp=1,1", stable, busy_ok);
        else n_pass++;
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h02) $display("FAIL single_status got=%h exp=02", got);
        else n_pass++;
    endtask

    task automatic test_overflow;
        int         waited, busy_cnt, low_cnt;
        logic [7:0] got;
        logic [8:0] slots, exp_slots;
        bit         stable, busy_ok;
        bus_wr(4'h1, 8'h01);
        bus_wr(4'h2, 8'h00);
        for (int i = 1; i <= 5; i++) bus_wr(4'h0, 8'(i));
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h4C) $display("FAIL ovf_status got=%h exp=4C", got);
        else n_pass++;
        bus_rd(4'h0, got);
        n_total++;
        if (got !== 8'h04) $display("FAIL ovf_level got=%h exp=04", got);
        else n_pass++;
        bus_wr(4'h2, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            capture_frame(1, waited, slots, stable, busy_ok);
            exp_slots = {1'b1, model_word(8'(i)), 1'b0};
            n_total++;
            if (waited !== 1 || slots !== exp_slots || !stable || !busy_ok)
                $display("FAIL ovf_frame%0d got=%b gap=%0d st=%0b bz=%0b exp=%b gap=1", i, slots, waited, stable, busy_ok, exp_slots);
            else n_pass++;
        end
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h0A) $display("FAIL ovf_sticky got=%h exp=0A", got);
        else n_pass++;
        bus_wr(4'h2, 8'h05);
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h02) $display("FAIL ovf_clear got=%h exp=02", got);
        else n_pass++;
        idle_watch(40, busy_cnt, low_cnt);
        n_total++;
        if (busy_cnt !== 0) $display("FAIL ovf_dropped_sent busy_cycles=%0d exp=0", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_flush;
        int         waited, busy_cnt, low_cnt;
        logic [7:0] got;
        logic [8:0] slots, exp_slots;
        bit         stable, busy_ok;
        bus_wr(4'h1, 8'h01);
        bus_wr(4'h2, 8'h00);
        for (int i = 0; i < 5; i++) bus_wr(4'h0, 8'(8'h11 * (i + 1)));
        bus_wr(4'h2, 8'h01);
        fork
            capture_frame(1, waited, slots, stable, busy_ok);
            begin
                repeat (4) @(posedge clk);
                bus_wr(4'h2, 8'h07);
            end
        join
        exp_slots = {1'b1, model_word(8'h11), 1'b0};
        n_total++;
        if (waited !== 1 || slots !== exp_slots || !stable || !busy_ok)
            $display("FAIL flush_frame got=%b gap=%0d st=%0b bz=%0b exp=%b", slots, waited, stable, busy_ok, exp_slots);
        else n_pass++;
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h02) $display("FAIL flush_status got=%h exp=02", got);
        else n_pass++;
        idle_watch(60, busy_cnt, low_cnt);
        n_total++;
        if (busy_cnt !== 0 || low_cnt !== 0) $display("FAIL flush_no_frames busy=%0d low=%0d exp=0,0", busy_cnt, low_cnt);
        else n_pass++;
    endtask

    task automatic test_en_clear;
        int         waited, busy_cnt, low_cnt;
        logic [7:0] got;
        logic [8:0] slots, exp_slots;
        bit         stable, busy_ok;
        bus_wr(4'h1, 8'h02);
        bus_wr(4'h2, 8'h00);
        bus_wr(4'h0, 8'h2A);
        bus_wr(4'h0, 8'h4B);
        bus_wr(4'h2, 8'h01);
        fork
            capture_frame(2, waited, slots, stable, busy_ok);
            begin
                repeat (3) @(posedge clk);
                bus_wr(4'h2, 8'h00);
            end
        join
        exp_slots = {1'b1, model_word(8'h2A), 1'b0};
        n_total++;
        if (waited !== 1 || slots !== exp_slots || !stable || !busy_ok)
            $display("FAIL enclr_frame got=%b gap=%0d st=%0b bz=%0b exp=%b", slots, waited, stable, busy_ok, exp_slots);
        else n_pass++;
        idle_watch(60, busy_cnt, low_cnt);
        n_total++;
        if (busy_cnt !== 0) $display("FAIL enclr_no_pop busy=%0d exp=0", busy_cnt);
        else n_pass++;
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h10) $display("FAIL enclr_status got=%h exp=10", got);
        else n_pass++;
        bus_wr(4'h2, 8'h02);
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h02) $display("FAIL enclr_flush got=%h exp=02", got);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [6:0] q [$];
        bit         ovf, stable, busy_ok;
        int         div, n, waited;
        logic [7:0] d, got;
        logic [8:0] slots, exp_slots;
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 3);
            bus_wr(4'h1, 8'(div));
            bus_wr(4'h2, 8'h00);
            n   = $urandom_range(1, 6);
            q.delete();
            ovf = 1'b0;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom_range(0, 255));
                bus_wr(4'h0, d);
                if (q.size() < 4) q.push_back(model_word(d));
                else ovf = 1'b1;
            end
            bus_rd(4'h0, got);
            n_total++;
            if (got !== 8'(q.size())) $display("FAIL rand%0d_level got=%h exp=%0d", it, got, q.size());
            else n_pass++;
            bus_wr(4'h2, 8'h01);
            while (q.size() > 0) begin
                capture_frame(div, waited, slots, stable, busy_ok);
                exp_slots = {1'b1, q.pop_front(), 1'b0};
                n_total++;
                if (waited !== 1 || slots !== exp_slots || !stable || !busy_ok)
                    $display("FAIL rand%0d_frame div=%0d got=%b gap=%0d st=%0b bz=%0b exp=%b", it, div, slots, waited, stable, busy_ok, exp_slots);
                else n_pass++;
            end
            bus_rd(4'h3, got);
            n_total++;
            if (got !== (ovf ? 8'h0A : 8'h02)) $display("FAIL rand%0d_status got=%h exp=%h", it, got, (ovf ? 8'h0A : 8'h02));
            else n_pass++;
            bus_wr(4'h2, 8'h04);
        end
    endtask

    task automatic test_reset_mid_frame;
        int         busy_cnt, low_cnt;
        logic [6:0] w;
        logic [7:0] got;
        w = model_word(8'h3C);
        bus_wr(4'h1, 8'h03);
        bus_wr(4'h2, 8'h01);
        bus_wr(4'h0, 8'h3C);
        bus_wr(4'h0, 8'h5A);
        repeat (16) @(posedge clk);
        #1;
        n_total++;
        if (uo_out[1:0] !== {1'b1, w[3]}) $display("FAIL rstmid_bit3 got=%b exp=%b", uo_out[1:0], {1'b1, w[3]});
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (uo_out !== 8'h01) $display("FAIL rstmid_async got=%h exp=01", uo_out);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus_rd(4'h3, got);
        n_total++;
        if (got !== 8'h02) $display("FAIL rstmid_status got=%h exp=02", got);
        else n_pass++;
        idle_watch(50, busy_cnt, low_cnt);
        n_total++;
        if (busy_cnt !== 0 || low_cnt !== 0) $display("FAIL rstmid_idle busy=%0d low=%0d exp=0,0", busy_cnt, low_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_flush();
        test_en_clear();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
